// File: rtl/c7bbiu_rd_sched.sv
// c7bbiu_rd_sched: BIU read-channel scheduler.
// Round-robin arbitration between IFU and LSU single-word reads. One AXI read
// is in flight at a time. The returning R beat is routed to whichever
// requester owns the transaction, and a cancelled IFU fetch is silently dropped.
module c7bbiu_rd_sched #(
    parameter logic [3:0] IFU_ID = 4'h0,
    parameter logic [3:0] LSU_ID = 4'h1
) (
    input  logic        clk,
    input  logic        resetn,
    // IFU read port
    input  logic        ifu_biu_rd_req,
    input  logic [31:0] ifu_biu_rd_addr,
    input  logic        ifu_biu_cancel,
    output logic        biu_ifu_rd_ack,
    output logic        biu_ifu_data_valid,
    output logic        biu_ifu_fault,
    // LSU read port
    input  logic        lsu_biu_rd_req,
    input  logic [31:0] lsu_biu_rd_addr,
    output logic        biu_lsu_rd_ack,
    output logic        biu_lsu_data_valid,
    output logic        biu_lsu_fault,
    // shared read data and status
    output logic [31:0] biu_rd_data,
    output logic        biu_rd_busy,
    // AXI AR channel
    input  logic        ext_biu_ar_ready,
    output logic        biu_ext_ar_valid,
    output logic [3:0]  biu_ext_ar_id,
    output logic [31:0] biu_ext_ar_addr,
    output logic [7:0]  biu_ext_ar_len,
    output logic [2:0]  biu_ext_ar_size,
    output logic [1:0]  biu_ext_ar_burst,
    output logic        biu_ext_ar_lock,
    output logic [3:0]  biu_ext_ar_cache,
    output logic [2:0]  biu_ext_ar_prot,
    // AXI R channel
    input  logic        ext_biu_r_valid,
    input  logic [3:0]  ext_biu_r_id,
    input  logic [31:0] ext_biu_r_data,
    input  logic        ext_biu_r_last,
    input  logic [1:0]  ext_biu_r_resp,
    output logic        biu_ext_r_ready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    state_t      state_q, state_d;
    logic [31:0] rdAddr_q, rdAddr_d;
    logic        owner_q, owner_d;
    logic        lastGrant_q, lastGrant_d;
    logic        drop_q, drop_d;

    logic grantIfu;
    logic grantLsu;
    logic beatLast;
    logic cancelHit;
    logic unusedRId;

    // Routing relies on the owner register, so the returned ID is not needed.
    assign unusedRId = ^ext_biu_r_id;

    // Only one request is granted per IDLE cycle. On a tie the side that was not granted last time wins.
    assign grantIfu = (state_q == IDLE) && ifu_biu_rd_req &&
                      (!lsu_biu_rd_req || (lastGrant_q == OWNER_LSU));
    assign grantLsu = (state_q == IDLE) && lsu_biu_rd_req && !grantIfu;

    assign beatLast = (state_q == DATA) && ext_biu_r_valid && ext_biu_r_last;

    // A cancel only matters while the IFU owns a transaction, including the cycle in which it is granted.
    assign cancelHit = ifu_biu_cancel &&
                       (((state_q != IDLE) && (owner_q == OWNER_IFU)) || grantIfu);

    // State register: an asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rdAddr_q    <= 32'h0;
            owner_q     <= OWNER_IFU;
            lastGrant_q <= OWNER_LSU;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdAddr_q    <= rdAddr_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            drop_q      <= drop_d;
        end
    end

    // Next-state logic: grant and latch in IDLE, address handshake in ADDR, wait for the last beat in DATA.
    always_comb begin
        state_d     = state_q;
        rdAddr_d    = rdAddr_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (grantIfu || grantLsu) begin
                    state_d     = ADDR;
                    rdAddr_d    = grantIfu ? ifu_biu_rd_addr : lsu_biu_rd_addr;
                    owner_d     = grantLsu ? OWNER_LSU : OWNER_IFU;
                    lastGrant_d = grantLsu ? OWNER_LSU : OWNER_IFU;
                end
            end
            ADDR: begin
                if (ext_biu_ar_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beatLast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The drop flag lives only for the current transaction.
        if (state_d == IDLE) begin
            drop_d = 1'b0;
        end else if (cancelHit) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Output decode: acks and data pulses are combinational, so they appear in the same cycle as their cause.
    always_comb begin
        biu_ifu_rd_ack     = grantIfu;
        biu_lsu_rd_ack     = grantLsu;
        biu_ext_ar_valid   = (state_q == ADDR);
        biu_ext_r_ready    = (state_q == DATA);
        biu_rd_busy        = (state_q != IDLE);
        biu_ifu_data_valid = beatLast && (owner_q == OWNER_IFU) && !drop_q && !ifu_biu_cancel;
        biu_lsu_data_valid = beatLast && (owner_q == OWNER_LSU);
        biu_ifu_fault      = biu_ifu_data_valid && (|ext_biu_r_resp);
        biu_lsu_fault      = biu_lsu_data_valid && (|ext_biu_r_resp);
    end

    // Every transaction is a single 32-bit INCR beat with default attributes.
    assign biu_ext_ar_addr  = rdAddr_q;
    assign biu_ext_ar_id    = (owner_q == OWNER_LSU) ? LSU_ID : IFU_ID;
    assign biu_ext_ar_len   = 8'd0;
    assign biu_ext_ar_size  = 3'b010;
    assign biu_ext_ar_burst = 2'b01;
    assign biu_ext_ar_lock  = 1'b0;
    assign biu_ext_ar_cache = 4'b0000;
    assign biu_ext_ar_prot  = 3'b000;
    assign biu_rd_data      = ext_biu_r_data;

endmodule

// File: tb/tb_c7bbiu_rd_sched.sv
// tb_c7bbiu_rd_sched: scenario-driven bench for the BIU read scheduler.
// Inputs are driven on the falling edge and outputs are sampled 1 ns later.
// Expected R-beat results go into a scoreboard queue when the beat is driven.
module tb_c7bbiu_rd_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ifu_biu_rd_req, ifu_biu_cancel, lsu_biu_rd_req;
    logic [31:0] ifu_biu_rd_addr, lsu_biu_rd_addr;
    logic        biu_ifu_rd_ack, biu_ifu_data_valid, biu_ifu_fault;
    logic        biu_lsu_rd_ack, biu_lsu_data_valid, biu_lsu_fault;
    logic [31:0] biu_rd_data;
    logic        biu_rd_busy;
    logic        ext_biu_ar_ready, biu_ext_ar_valid, biu_ext_ar_lock;
    logic [3:0]  biu_ext_ar_id, biu_ext_ar_cache;
    logic [31:0] biu_ext_ar_addr;
    logic [7:0]  biu_ext_ar_len;
    logic [2:0]  biu_ext_ar_size, biu_ext_ar_prot;
    logic [1:0]  biu_ext_ar_burst;
    logic        ext_biu_r_valid, ext_biu_r_last, biu_ext_r_ready;
    logic [3:0]  ext_biu_r_id;
    logic [31:0] ext_biu_r_data;
    logic [1:0]  ext_biu_r_resp;

    typedef struct packed {
        logic        ifuV;
        logic        ifuF;
        logic        lsuV;
        logic        lsuF;
        logic [31:0] data;
    } exp_t;

    exp_t sbQ[$];
    int   compared = 0;
    int   mismatched = 0;

    c7bbiu_rd_sched dut (
        .clk(clk), .resetn(resetn),
        .ifu_biu_rd_req(ifu_biu_rd_req), .ifu_biu_rd_addr(ifu_biu_rd_addr),
        .ifu_biu_cancel(ifu_biu_cancel), .biu_ifu_rd_ack(biu_ifu_rd_ack),
        .biu_ifu_data_valid(biu_ifu_data_valid), .biu_ifu_fault(biu_ifu_fault),
        .lsu_biu_rd_req(lsu_biu_rd_req), .lsu_biu_rd_addr(lsu_biu_rd_addr),
        .biu_lsu_rd_ack(biu_lsu_rd_ack), .biu_lsu_data_valid(biu_lsu_data_valid),
        .biu_lsu_fault(biu_lsu_fault), .biu_rd_data(biu_rd_data), .biu_rd_busy(biu_rd_busy),
        .ext_biu_ar_ready(ext_biu_ar_ready), .biu_ext_ar_valid(biu_ext_ar_valid),
        .biu_ext_ar_id(biu_ext_ar_id), .biu_ext_ar_addr(biu_ext_ar_addr),
        .biu_ext_ar_len(biu_ext_ar_len), .biu_ext_ar_size(biu_ext_ar_size),
        .biu_ext_ar_burst(biu_ext_ar_burst), .biu_ext_ar_lock(biu_ext_ar_lock),
        .biu_ext_ar_cache(biu_ext_ar_cache), .biu_ext_ar_prot(biu_ext_ar_prot),
        .ext_biu_r_valid(ext_biu_r_valid), .ext_biu_r_id(ext_biu_r_id),
        .ext_biu_r_data(ext_biu_r_data), .ext_biu_r_last(ext_biu_r_last),
        .ext_biu_r_resp(ext_biu_r_resp), .biu_ext_r_ready(biu_ext_r_ready)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Puts every input back into its quiet state.
    task automatic idleInputs();
        ifu_biu_rd_req   = 1'b0;
        ifu_biu_rd_addr  = 32'h0;
        ifu_biu_cancel   = 1'b0;
        lsu_biu_rd_req   = 1'b0;
        lsu_biu_rd_addr  = 32'h0;
        ext_biu_ar_ready = 1'b0;
        ext_biu_r_valid  = 1'b0;
        ext_biu_r_id     = 4'h0;
        ext_biu_r_data   = 32'h0;
        ext_biu_r_last   = 1'b0;
        ext_biu_r_resp   = 2'b00;
    endtask

    // Drives a single-beat R response for the current cycle.
    task automatic driveBeat(input logic [31:0] d, input logic [1:0] resp);
        ext_biu_r_valid = 1'b1;
        ext_biu_r_last  = 1'b1;
        ext_biu_r_data  = d;
        ext_biu_r_resp  = resp;
    endtask

    // Requests one read with a zero-wait AR slave. Returns just after the falling edge of the ADDR cycle.
    task automatic issueRead(input logic isLsu, input logic [31:0] addr);
        @(negedge clk);
        idleInputs();
        if (isLsu) begin
            lsu_biu_rd_req  = 1'b1;
            lsu_biu_rd_addr = addr;
        end else begin
            ifu_biu_rd_req  = 1'b1;
            ifu_biu_rd_addr = addr;
        end
        ext_biu_ar_ready = 1'b1;
        @(negedge clk);
        ifu_biu_rd_req = 1'b0;
        lsu_biu_rd_req = 1'b0;
    endtask

    function automatic exp_t mkExp(input logic iv, input logic ifl, input logic lv,
                                   input logic lf, input logic [31:0] d);
        mkExp = {iv, ifl, lv, lf, d};
    endfunction

    function automatic exp_t observed();
        observed = {biu_ifu_data_valid, biu_ifu_fault, biu_lsu_data_valid, biu_lsu_fault, biu_rd_data};
    endfunction

    task automatic test_reset();
        logic [10:0] got;
        exp_t e;
        @(negedge clk);
        idleInputs();
        resetn = 1'b0;
        #1;
        got = {biu_rd_busy, biu_ext_ar_valid, biu_ext_r_ready, biu_ifu_rd_ack, biu_lsu_rd_ack,
               biu_ifu_data_valid, biu_ifu_fault, biu_lsu_data_valid, biu_lsu_fault,
               |biu_ext_ar_addr, |biu_ext_ar_id};
        compared++;
        if (got !== 11'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", got, 11'b0);
        end
        @(negedge clk);
        resetn = 1'b1;
        driveBeat(32'h0000_1111, 2'b00);
        sbQ.push_back(mkExp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1111));
        #1;
        e = sbQ.pop_front();
        compared++;
        if (observed() !== e) begin
            mismatched++;
            $display("[TB] FAIL reset_idle_beat: got %h expected %h", observed(), e);
        end
        @(negedge clk);
        idleInputs();
    endtask

    task automatic test_ifu_basic();
        exp_t e;
        @(negedge clk);
        idleInputs();
        ifu_biu_rd_req   = 1'b1;
        ifu_biu_rd_addr  = 32'h1000_0000;
        ext_biu_ar_ready = 1'b1;
        #1;
        compared++;
        if ({biu_ifu_rd_ack, biu_lsu_rd_ack, biu_ext_ar_valid, biu_rd_busy} !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL basic_ack: got %b expected %b",
                     {biu_ifu_rd_ack, biu_lsu_rd_ack, biu_ext_ar_valid, biu_rd_busy}, 4'b1000);
        end
        @(negedge clk);
        ifu_biu_rd_req = 1'b0;
        #1;
        compared++;
        if ({biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, biu_rd_busy, biu_ifu_rd_ack} !==
            {1'b1, 4'h0, 32'h1000_0000, 1'b1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL basic_ar: got valid=%b id=%h addr=%h expected valid=1 id=0 addr=10000000",
                     biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr);
        end
        compared++;
        if ({biu_ext_ar_len, biu_ext_ar_size, biu_ext_ar_burst, biu_ext_ar_lock, biu_ext_ar_cache, biu_ext_ar_prot} !==
            {8'd0, 3'b010, 2'b01, 1'b0, 4'b0000, 3'b000}) begin
            mismatched++;
            $display("[TB] FAIL basic_ar_attr: got len=%h size=%b burst=%b expected len=00 size=010 burst=01",
                     biu_ext_ar_len, biu_ext_ar_size, biu_ext_ar_burst);
        end
        @(negedge clk);
        ext_biu_ar_ready = 1'b0;
        #1;
        compared++;
        if ({biu_ext_r_ready, biu_ext_ar_valid, biu_ifu_data_valid} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL basic_rready: got %b expected %b",
                     {biu_ext_r_ready, biu_ext_ar_valid, biu_ifu_data_valid}, 3'b100);
        end
        @(negedge clk);
        driveBeat(32'hDEAD_BEEF, 2'b00);
        sbQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF));
        #1;
        e = sbQ.pop_front();
        compared++;
        if (observed() !== e) begin
            mismatched++;
            $display("[TB] FAIL basic_data: got %h expected %h", observed(), e);
        end
        @(negedge clk);
        idleInputs();
        #1;
        compared++;
        if (biu_rd_busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_idle: got busy=%b expected 0", biu_rd_busy);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic expIfu;
        @(negedge clk);
        idleInputs();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        for (int g = 0; g < 4; g++) begin
            expIfu = (g % 2 == 0);
            @(negedge clk);
            ifu_biu_rd_req   = 1'b1;
            lsu_biu_rd_req   = 1'b1;
            ifu_biu_rd_addr  = 32'h3000_0000 + 32'(g * 4);
            lsu_biu_rd_addr  = 32'h4000_0000 + 32'(g * 4);
            ext_biu_ar_ready = 1'b1;
            ext_biu_r_valid  = 1'b0;
            ext_biu_r_last   = 1'b0;
            #1;
            compared++;
            if ({biu_ifu_rd_ack, biu_lsu_rd_ack} !== {expIfu, !expIfu}) begin
                mismatched++;
                $display("[TB] FAIL rr_ack%0d: got %b expected %b", g,
                         {biu_ifu_rd_ack, biu_lsu_rd_ack}, {expIfu, !expIfu});
            end
            @(negedge clk);
            #1;
            compared++;
            if ({biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, biu_ifu_rd_ack, biu_lsu_rd_ack} !==
                {1'b1, (expIfu ? 4'h0 : 4'h1),
                 (expIfu ? 32'h3000_0000 : 32'h4000_0000) + 32'(g * 4), 2'b00}) begin
                mismatched++;
                $display("[TB] FAIL rr_ar%0d: got valid=%b id=%h addr=%h acks=%b%b expected ifu_owner=%b",
                         g, biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr,
                         biu_ifu_rd_ack, biu_lsu_rd_ack, expIfu);
            end
            @(negedge clk);
            driveBeat(32'hA000_0000 | 32'(g), 2'b00);
            sbQ.push_back(mkExp(expIfu, 1'b0, !expIfu, 1'b0, 32'hA000_0000 | 32'(g)));
            #1;
            e = sbQ.pop_front();
            compared++;
            if (observed() !== e) begin
                mismatched++;
                $display("[TB] FAIL rr_data%0d: got %h expected %h", g, observed(), e);
            end
        end
        @(negedge clk);
        idleInputs();
    endtask

    task automatic test_ar_stall();
        exp_t e;
        @(negedge clk);
        idleInputs();
        ifu_biu_rd_req  = 1'b1;
        ifu_biu_rd_addr = 32'h2000_0040;
        #1;
        compared++;
        if (biu_ifu_rd_ack !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stall_ack: got %b expected 1", biu_ifu_rd_ack);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifu_biu_rd_req = 1'b0;
            lsu_biu_rd_req = 1'b1;
            lsu_biu_rd_addr = 32'h4444_0000;
            #1;
            compared++;
            if ({biu_ext_ar_valid, biu_ext_ar_addr, biu_ext_ar_id, biu_ifu_rd_ack, biu_lsu_rd_ack} !==
                {1'b1, 32'h2000_0040, 4'h0, 2'b00}) begin
                mismatched++;
                $display("[TB] FAIL stall_hold%0d: got valid=%b addr=%h id=%h acks=%b%b expected valid=1 addr=20000040 id=0 acks=00",
                         i, biu_ext_ar_valid, biu_ext_ar_addr, biu_ext_ar_id, biu_ifu_rd_ack, biu_lsu_rd_ack);
            end
        end
        @(negedge clk);
        ext_biu_ar_ready = 1'b1;
        @(negedge clk);
        ext_biu_ar_ready = 1'b0;
        lsu_biu_rd_req   = 1'b0;
        driveBeat(32'h55AA_1234, 2'b00);
        sbQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 1'b0, 32'h55AA_1234));
        #1;
        e = sbQ.pop_front();
        compared++;
        if (observed() !== e) begin
            mismatched++;
            $display("[TB] FAIL stall_data: got %h expected %h", observed(), e);
        end
        @(negedge clk);
        idleInputs();
    endtask

    task automatic test_cancel();
        exp_t e;
        // Cancel with nothing in flight must be ignored.
        @(negedge clk);
        idleInputs();
        ifu_biu_cancel = 1'b1;
        #1;
        compared++;
        if ({biu_rd_busy, biu_ifu_rd_ack} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL cancel_idle: got %b expected 00", {biu_rd_busy, biu_ifu_rd_ack});
        end
        // Cancel pulsed in DATA, beat arrives later.
        issueRead(1'b0, 32'h1000_0100);
        @(negedge clk);
        ext_biu_ar_ready = 1'b0;
        ifu_biu_cancel   = 1'b1;
        #1;
        compared++;
        if ({biu_ext_r_ready, biu_ifu_data_valid} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL cancel_data_state: got %b expected 10", {biu_ext_r_ready, biu_ifu_data_valid});
        end
        @(negedge clk);
        ifu_biu_cancel = 1'b0;
        driveBeat(32'h1234_5678, 2'b10);
        sbQ.push_back(mkExp(1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678));
        #1;
        e = sbQ.pop_front();
        compared++;
        if ({observed(), biu_ext_r_ready} !== {e, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL cancel_drop: got %h rready=%b expected %h rready=1", observed(), biu_ext_r_ready, e);
        end
        @(negedge clk);
        idleInputs();
        #1;
        compared++;
        if (biu_rd_busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL cancel_done: got busy=%b expected 0", biu_rd_busy);
        end
        // The next IFU read must return normally.
        issueRead(1'b0, 32'h1000_0200);
        @(negedge clk);
        driveBeat(32'hCAFE_F00D, 2'b00);
        sbQ.push_back(mkExp(1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D));
        #1;
        e = sbQ.pop_front();
        compared++;
        if (observed() !== e) begin
            mismatched++;
            $display("[TB] FAIL cancel_after: got %h expected %h", observed(), e);
        end
        // Cancel in the same cycle as the beat drops it.
        issueRead(1'b0, 32'h1000_0300);
        @(negedge clk);
        ifu_biu_cancel = 1'b1;
        driveBeat(32'h0F0F_0F0F, 2'b11);
        sbQ.push_back(mkExp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0F0F_0F0F));
        #1;
        e = sbQ.pop_front();
        compared++;
        if (observed() !== e) begin
            mismatched++;
            $display("[TB] FAIL cancel_same_cycle: got %h expected %h", observed(), e);
        end
        // A cancel during an LSU transaction has no effect.
        issueRead(1'b1, 32'h5000_0100);
        @(negedge clk);
        ifu_biu_cancel = 1'b1;
        driveBeat(32'h7777_8888, 2'b00);
        sbQ.push_back(mkExp(1'b0, 1'b0, 1'b1, 1'b0, 32'h7777_8888));
        #1;
        e = sbQ.pop_front();
        compared++;
        if (observed() !== e) begin
            mismatched++;
            $display("[TB] FAIL cancel_lsu_unaffected: got %h expected %h", observed(), e);
        end
        @(negedge clk);
        idleInputs();
    endtask

    task automatic test_lsu_fault();
        exp_t e;
        issueRead(1'b1, 32'h5000_0008);
        #1;
        compared++;
        if ({biu_ext_ar_valid, biu_ext_ar_id} !== {1'b1, 4'h1}) begin
            mismatched++;
            $display("[TB] FAIL fault_ar_id: got valid=%b id=%h expected valid=1 id=1", biu_ext_ar_valid, biu_ext_ar_id);
        end
        @(negedge clk);
        ext_biu_ar_ready = 1'b0;
        driveBeat(32'h0, 2'b10);
        sbQ.push_back(mkExp(1'b0, 1'b0, 1'b1, 1'b1, 32'h0));
        #1;
        e = sbQ.pop_front();
        compared++;
        if (observed() !== e) begin
            mismatched++;
            $display("[TB] FAIL lsu_fault: got %h expected %h", observed(), e);
        end
        @(negedge clk);
        idleInputs();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge clk);
        idleInputs();
        ifu_biu_rd_req  = 1'b1;
        ifu_biu_rd_addr = 32'h6000_0000;
        @(negedge clk);
        ifu_biu_rd_req = 1'b0;
        #1;
        compared++;
        if ({biu_ext_ar_valid, biu_rd_busy} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL rstmid_addr: got %b expected 11", {biu_ext_ar_valid, biu_rd_busy});
        end
        #1;
        resetn = 1'b0;
        #1;
        compared++;
        if ({biu_ext_ar_valid, biu_rd_busy, biu_ext_r_ready} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL rstmid_abort: got %b expected 000", {biu_ext_ar_valid, biu_rd_busy, biu_ext_r_ready});
        end
        @(negedge clk);
        resetn = 1'b1;
        lsu_biu_rd_req   = 1'b1;
        lsu_biu_rd_addr  = 32'h7000_0000;
        ext_biu_ar_ready = 1'b1;
        #1;
        compared++;
        if ({biu_lsu_rd_ack, biu_ifu_rd_ack} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL rstmid_ack: got %b expected 10", {biu_lsu_rd_ack, biu_ifu_rd_ack});
        end
        @(negedge clk);
        lsu_biu_rd_req = 1'b0;
        #1;
        compared++;
        if ({biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr} !== {1'b1, 4'h1, 32'h7000_0000}) begin
            mismatched++;
            $display("[TB] FAIL rstmid_ar: got valid=%b id=%h addr=%h expected valid=1 id=1 addr=70000000",
                     biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr);
        end
        @(negedge clk);
        driveBeat(32'h0BAD_F00D, 2'b00);
        sbQ.push_back(mkExp(1'b0, 1'b0, 1'b1, 1'b0, 32'h0BAD_F00D));
        #1;
        e = sbQ.pop_front();
        compared++;
        if (observed() !== e) begin
            mismatched++;
            $display("[TB] FAIL rstmid_data: got %h expected %h", observed(), e);
        end
        @(negedge clk);
        idleInputs();
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        idleInputs();
        test_reset();
        test_ifu_basic();
        test_round_robin();
        test_ar_stall();
        test_cancel();
        test_lsu_fault();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
